syn_pcm_cap_writer: RTL and testbench

- Acortex-side capture stage that writes the PCM sample RAM.
- Takes stereo sample pairs from the codec deserializer and buffers them in a small FIFO.
- Writes left and right words simultaneously to the L/R sample-RAM slave ports at sequential addresses 0..127.
- Stops only on a bank boundary, so the RAM's bank toggle (write to the all-ones address) always stays aligned.

---
 rtl/syn_pcm_cap_writer.sv | 188 ++++++++++++++++++
 tb/tb_syn_pcm_cap_writer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syn_pcm_cap_writer.sv
// PCM capture writer: buffers stereo pairs and writes them to the L/R
// sample RAM, stopping only on a bank boundary.
module syn_pcm_cap_writer #(
  parameter int P_MEM_DATA_W = 32,
  parameter int P_MEM_ADDR_W = 7,
  parameter int P_FIFO_DEPTH = 4
) (
  input  logic                    clk_ir,
  input  logic                    rst_ih,
  input  logic                    cfg_en,
  input  logic                    wr_stall,
  input  logic                    pcm_valid,
  input  logic [P_MEM_DATA_W-1:0] pcm_ldata,
  input  logic [P_MEM_DATA_W-1:0] pcm_rdata,
  output logic                    pcm_ready,
  output logic [P_MEM_ADDR_W-1:0] lmem_addr,
  output logic [P_MEM_DATA_W-1:0] lmem_wdata,
  output logic                    lmem_wren,
  output logic                    lmem_rden,
  output logic [P_MEM_ADDR_W-1:0] rmem_addr,
  output logic [P_MEM_DATA_W-1:0] rmem_wdata,
  output logic                    rmem_wren,
  output logic                    rmem_rden,
  output logic                    bank_done_p,
  output logic [15:0]             bank_cnt,
  output logic [15:0]             ovrflw_cnt,
  output logic                    busy
);

  localparam int PTR_W = $clog2(P_FIFO_DEPTH);
  localparam logic [PTR_W:0] FILL_FULL =
    (PTR_W+1)'(P_FIFO_DEPTH);
  localparam logic [P_MEM_ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   fill_q, fill_d;
  logic             full_q, full_d;

  logic [P_MEM_ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [P_MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [P_MEM_DATA_W-1:0] ldat_q, ldat_d;
  logic [P_MEM_DATA_W-1:0] rdat_q, rdat_d;
  logic                    wren_q, wren_d;
  logic                    done_q, done_d;
  logic [15:0]             bank_q, bank_d;
  logic [15:0]             ovf_q, ovf_d;

  logic [P_MEM_DATA_W-1:0] fifo_l_q [P_FIFO_DEPTH];
  logic [P_MEM_DATA_W-1:0] fifo_r_q [P_FIFO_DEPTH];

  logic active;
  logic push;
  logic pop;
  logic wrap;
  logic stop;

  // wrap marks the visible write to the last bank address; in DRAIN it
  // ends the capture, so no further pop may start a new bank
  assign active = (state_q != ST_IDLE);
  assign push   = pcm_valid & active & ~full_q;
  assign wrap   = wren_q & (addr_q == ADDR_MAX);
  assign stop   = (state_q == ST_DRAIN) & ~cfg_en & wrap;
  assign pop    = active & (fill_q != '0) & ~wr_stall & ~stop;

  // next-state logic for FSM, FIFO pointers, write port and counters
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    full_d   = full_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    ldat_d   = ldat_q;
    rdat_d   = rdat_q;
    wren_d   = 1'b0;
    done_d   = wrap;
    bank_d   = bank_q;
    ovf_d    = ovf_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      wren_d   = 1'b1;
      addr_d   = wcnt_q;
      ldat_d   = fifo_l_q[rd_ptr_q];
      rdat_d   = fifo_r_q[rd_ptr_q];
      wcnt_d   = wcnt_q + P_MEM_ADDR_W'(1);
    end
    fill_d = fill_q + (PTR_W+1)'(push)
                    - (PTR_W+1)'(pop);
    full_d = (fill_d == FILL_FULL);

    if (wrap) begin
      bank_d = bank_q + 16'd1;
    end
    if (pcm_valid & active & full_q
        & (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_en) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!cfg_en) begin
          if ((wcnt_q == '0) && (fill_q == '0))
            state_d = ST_IDLE;
          else
            state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cfg_en)    state_d = ST_CAPTURE;
        else if (wrap) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and control registers
  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      full_q   <= 1'b0;
      wcnt_q   <= '0;
      addr_q   <= '0;
      ldat_q   <= '0;
      rdat_q   <= '0;
      wren_q   <= 1'b0;
      done_q   <= 1'b0;
      bank_q   <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      full_q   <= full_d;
      wcnt_q   <= wcnt_d;
      addr_q   <= addr_d;
      ldat_q   <= ldat_d;
      rdat_q   <= rdat_d;
      wren_q   <= wren_d;
      done_q   <= done_d;
      bank_q   <= bank_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge clk_ir) begin
    if (push) begin
      fifo_l_q[wr_ptr_q] <= pcm_ldata;
      fifo_r_q[wr_ptr_q] <= pcm_rdata;
    end
  end

  assign pcm_ready   = active & ~full_q;
  assign busy        = active;
  assign lmem_addr   = addr_q;
  assign rmem_addr   = addr_q;
  assign lmem_wdata  = ldat_q;
  assign rmem_wdata  = rdat_q;
  assign lmem_wren   = wren_q;
  assign rmem_wren   = wren_q;
  assign lmem_rden   = 1'b0;
  assign rmem_rden   = 1'b0;
  assign bank_done_p = done_q;
  assign bank_cnt    = bank_q;
  assign ovrflw_cnt  = ovf_q;

endmodule

// File: tb/tb_syn_pcm_cap_writer.sv
// Bench for syn_pcm_cap_writer: directed phases plus random traffic
// checked every cycle against a queue-based reference model.
module tb_syn_pcm_cap_writer;

  localparam int DW = 32;
  localparam int AW = 7;
  localparam int FD = 4;

  logic          clk_ir = 1'b0;
  logic          rst_ih;
  logic          cfg_en;
  logic          wr_stall;
  logic          pcm_valid;
  logic [DW-1:0] pcm_ldata;
  logic [DW-1:0] pcm_rdata;
  logic          pcm_ready;
  logic [AW-1:0] lmem_addr;
  logic [DW-1:0] lmem_wdata;
  logic          lmem_wren;
  logic          lmem_rden;
  logic [AW-1:0] rmem_addr;
  logic [DW-1:0] rmem_wdata;
  logic          rmem_wren;
  logic          rmem_rden;
  logic          bank_done_p;
  logic [15:0]   bank_cnt;
  logic [15:0]   ovrflw_cnt;
  logic          busy;

  syn_pcm_cap_writer #(
    .P_MEM_DATA_W(DW),
    .P_MEM_ADDR_W(AW),
    .P_FIFO_DEPTH(FD)
  ) dut (
    .clk_ir(clk_ir),
    .rst_ih(rst_ih),
    .cfg_en(cfg_en),
    .wr_stall(wr_stall),
    .pcm_valid(pcm_valid),
    .pcm_ldata(pcm_ldata),
    .pcm_rdata(pcm_rdata),
    .pcm_ready(pcm_ready),
    .lmem_addr(lmem_addr),
    .lmem_wdata(lmem_wdata),
    .lmem_wren(lmem_wren),
    .lmem_rden(lmem_rden),
    .rmem_addr(rmem_addr),
    .rmem_wdata(rmem_wdata),
    .rmem_wren(rmem_wren),
    .rmem_rden(rmem_rden),
    .bank_done_p(bank_done_p),
    .bank_cnt(bank_cnt),
    .ovrflw_cnt(ovrflw_cnt),
    .busy(busy)
  );

  always #5 clk_ir = ~clk_ir;

  int cyc = 0;
  always @(posedge clk_ir) cyc <= cyc + 1;

  int n_tot = 0;
  int n_bad = 0;

  task automatic check(string tag,
                       logic [63:0] got,
                       logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  // reference model: 0 idle, 1 capture, 2 drain
  int          m_st;
  logic [31:0] q_l[$];
  logic [31:0] q_r[$];
  int          m_wcnt;
  bit          m_wren;
  logic [6:0]  m_addr;
  logic [31:0] m_wl;
  logic [31:0] m_wr;
  bit          m_done;
  logic [15:0] m_bank;
  logic [15:0] m_ovf;

  bit acc;
  int n_hs;
  int n_wr;
  int n_done;
  int first_wr_addr;
  int first_wr_cyc;
  int done_cyc[2];

  task automatic model_step(bit rst, bit cfg,
                            bit stall, bit vld,
                            logic [31:0] l,
                            logic [31:0] r);
    bit act, rdy, push, pop, wrap;
    int sz;
    if (rst) begin
      m_st = 0;
      q_l.delete();
      q_r.delete();
      m_wcnt = 0;
      m_wren = 0;
      m_addr = '0;
      m_wl = '0;
      m_wr = '0;
      m_done = 0;
      m_bank = '0;
      m_ovf = '0;
      return;
    end
    sz = q_l.size();
    act = (m_st != 0);
    rdy = act && (sz < FD);
    push = vld && rdy;
    wrap = m_wren && (m_addr == 7'h7f);
    pop = act && (sz > 0) && !stall
          && !(m_st == 2 && !cfg && wrap);
    if (vld && act && !rdy && m_ovf != 16'hffff)
      m_ovf = m_ovf + 16'd1;
    m_done = wrap;
    if (wrap) m_bank = m_bank + 16'd1;
    case (m_st)
      0: if (cfg) m_st = 1;
      1: if (!cfg)
           m_st = (m_wcnt == 0 && sz == 0) ? 0 : 2;
      default: begin
        if (cfg) m_st = 1;
        else if (wrap) m_st = 0;
      end
    endcase
    m_wren = pop;
    if (pop) begin
      m_addr = 7'(m_wcnt);
      m_wl = q_l.pop_front();
      m_wr = q_r.pop_front();
      m_wcnt = (m_wcnt + 1) % 128;
    end
    if (push) begin
      q_l.push_back(l);
      q_r.push_back(r);
    end
  endtask

  task automatic step(bit rst, bit cfg,
                      bit stall, bit vld,
                      logic [31:0] l,
                      logic [31:0] r);
    rst_ih = rst;
    cfg_en = cfg;
    wr_stall = stall;
    pcm_valid = vld;
    pcm_ldata = l;
    pcm_rdata = r;
    acc = !rst && vld && m_st != 0
          && q_l.size() < FD;
    if (vld && pcm_ready) n_hs++;
    model_step(rst, cfg, stall, vld, l, r);
    @(negedge clk_ir);
    check("ready", 64'(pcm_ready),
          64'(m_st != 0 && q_l.size() < FD));
    check("wren", {lmem_wren, rmem_wren},
          {m_wren, m_wren});
    check("addr", {lmem_addr, rmem_addr},
          {m_addr, m_addr});
    check("wdata", {lmem_wdata, rmem_wdata},
          {m_wl, m_wr});
    check("rden", {lmem_rden, rmem_rden}, 0);
    check("done", 64'(bank_done_p), 64'(m_done));
    check("bank", bank_cnt, m_bank);
    check("ovf", ovrflw_cnt, m_ovf);
    check("busy", 64'(busy), 64'(m_st != 0));
    if (lmem_wren) begin
      n_wr++;
      if (first_wr_addr < 0) begin
        first_wr_addr = int'(lmem_addr);
        first_wr_cyc = cyc;
      end
    end
    if (bank_done_p) begin
      if (n_done < 2) done_cyc[n_done] = cyc;
      n_done++;
    end
  endtask

  task automatic clr_obs();
    n_hs = 0;
    n_wr = 0;
    n_done = 0;
    first_wr_addr = -1;
    first_wr_cyc = -1;
  endtask

  initial begin
    int i, g, need, hs_cyc, c;
    bit cfg_r;
    rst_ih = 1'b1;
    cfg_en = 1'b0;
    wr_stall = 1'b0;
    pcm_valid = 1'b0;
    pcm_ldata = '0;
    pcm_rdata = '0;
    clr_obs();
    @(negedge clk_ir);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    check("reset_state",
          {busy, pcm_ready, lmem_wren, bank_done_p,
           lmem_addr, bank_cnt, ovrflw_cnt}, 0);

    // one full bank, back to back
    step(0, 1, 0, 0, 0, 0);
    clr_obs();
    i = 0; g = 0; hs_cyc = -1;
    while (i < 128 && g < 1000) begin
      c = cyc;
      step(0, 1, 0, 1, i, 32'h8000_0000 | i);
      if (acc) begin
        if (hs_cyc < 0) hs_cyc = c;
        i++;
      end
      g++;
    end
    repeat (6) step(0, 1, 0, 0, 0, 0);
    check("p1_pairs", i, 128);
    check("p1_writes", n_wr, 128);
    check("p1_latency", first_wr_cyc - hs_cyc, 2);
    check("p1_first_addr", first_wr_addr, 0);
    check("p1_done", n_done, 1);
    check("p1_bank", bank_cnt, 1);
    check("p1_ovf", ovrflw_cnt, 0);

    // stall fills the FIFO, the rest overflow
    clr_obs();
    repeat (10) step(0, 1, 1, 1, $urandom, $urandom);
    check("stall_acc", n_hs, 4);
    check("stall_ovf", ovrflw_cnt, 6);
    check("stall_nowr", n_wr, 0);
    repeat (6) step(0, 1, 0, 0, 0, 0);
    check("stall_wr", n_wr, 4);
    check("stall_first", first_wr_addr, 0);
    check("stall_last", lmem_addr, 3);

    // disable mid-bank: drain to the boundary
    g = 0;
    while (m_wcnt != 50 && g < 500) begin
      step(0, 1, 0, 1, $urandom, $urandom);
      g++;
    end
    check("p3_reach50", m_wcnt, 50);
    g = 0;
    while (m_st != 0 && g < 2000) begin
      step(0, 0, $urandom_range(0, 3) == 0, 1,
           $urandom, $urandom);
      g++;
    end
    check("drain_busy", busy, 0);
    check("drain_ready", pcm_ready, 0);
    check("drain_bank", bank_cnt, 2);
    repeat (3) step(0, 0, 0, 1, $urandom, $urandom);
    clr_obs();
    g = 0;
    while (first_wr_addr < 0 && g < 50) begin
      step(0, 1, 0, 1, $urandom, $urandom);
      g++;
    end
    check("reen_addr", first_wr_addr, 0);

    // finish the bank, then disable with FIFO empty
    need = 128 - m_wcnt - q_l.size();
    i = 0; g = 0;
    while (i < need && g < 600) begin
      step(0, 1, 0, 1, $urandom, $urandom);
      if (acc) i++;
      g++;
    end
    g = 0;
    while (!m_done && g < 300) begin
      step(0, 1, 0, 0, 0, 0);
      g++;
    end
    check("p4_bank", bank_cnt, 3);
    step(0, 0, 0, 0, 0, 0);
    check("p4_idle", busy, 0);
    clr_obs();
    repeat (4) step(0, 0, 0, 0, 0, 0);
    check("p4_nowr", n_wr, 0);

    // reset mid-bank with a partly full FIFO
    g = 0;
    while (m_wcnt != 37 && g < 500) begin
      step(0, 1, 0, 1, $urandom, $urandom);
      g++;
    end
    g = 0;
    while (q_l.size() < 3 && g < 20) begin
      step(0, 1, 1, 1, $urandom, $urandom);
      g++;
    end
    check("p5_fifo3", q_l.size(), 3);
    step(1, 1, 0, 1, $urandom, $urandom);
    check("p5_rst_out",
          {busy, pcm_ready, lmem_wren, rmem_wren,
           bank_done_p, lmem_addr, rmem_addr,
           bank_cnt, ovrflw_cnt}, 0);
    check("p5_rst_data",
          {lmem_wdata, rmem_wdata}, 0);
    clr_obs();
    g = 0;
    while (first_wr_addr < 0 && g < 50) begin
      step(0, 1, 0, 1, $urandom, $urandom);
      g++;
    end
    check("p5_first_addr", first_wr_addr, 0);

    // 300 pairs sustained
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    clr_obs();
    i = 0; g = 0;
    while (i < 300 && g < 2000) begin
      step(0, 1, 0, 1, $urandom, $urandom);
      if (acc) i++;
      g++;
    end
    repeat (6) step(0, 1, 0, 0, 0, 0);
    check("p6_pairs", i, 300);
    check("p6_writes", n_wr, 300);
    check("p6_done", n_done, 2);
    check("p6_spacing",
          done_cyc[1] - done_cyc[0], 128);
    check("p6_bank", bank_cnt, 2);
    check("p6_last", lmem_addr, 43);
    check("p6_ovf", ovrflw_cnt, 0);

    // random traffic
    cfg_r = 1'b1;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 39) == 0)
        cfg_r = ~cfg_r;
      step($urandom_range(0, 299) == 0, cfg_r,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0,
           $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d",
             n_tot, n_bad);
    $finish;
  end

endmodule
